latch_capture_rx: RTL
=====================

// Module: latch_capture_rx
// PURPOSE
//  Clocked reader for a d_latch-style transparent storage bank. Watches the
//  asynchronous latch enable. When the latch closes (enable 1->0), it samples the
//  now-stable latched value into a small FIFO. The FIFO is presented downstream
//  over a valid/ready handshake, so the latch writer and the clocked datapath
//  need no shared timing.
// PARAMETERS
//  WIDTH        8   width of latched data bus lat_q / out_data
//  DEPTH        4   FIFO entries; power of two, >= 2
//  SYNC_STAGES  2   synchronizer flops on lat_en and lat_q; >= 2
// PORTS
//  clk        in   1                  rising-edge clock
//  reset      in   1                  synchronous, active-low reset
//  lat_en     in   1                  async latch enable (1 = transparent, 0 = holding)
//  lat_q      in   WIDTH              async latch output value
//  out_data   out  WIDTH              head-of-FIFO data
//  out_valid  out  1                  out_data holds a captured word
//  out_ready  in   1                  downstream accepts word when out_valid && out_ready
//  count      out  $clog2(DEPTH)+1    FIFO occupancy, 0..DEPTH
//  overflow   out  1                  sticky: a capture was dropped because the FIFO was full
// BEHAVIOUR
//  - Reset (reset==0 at a clk edge): every flop is cleared, including both sync
//    chains, FSM = S_IDLE, FIFO pointers, count=0, out_valid=0, out_data=0 and
//    overflow=0. This also applies mid-operation: the FIFO is flushed and any
//    partially seen pulse is discarded.
//  - Sync: lat_en and lat_q each pass through SYNC_STAGES flops. Their outputs are
//    en_s and q_s.
//  - FSM (en_s-driven):
//      S_IDLE    -> S_OPEN when en_s=1
//      S_OPEN    -> S_CAPTURE when en_s=0
//      S_CAPTURE -> S_OPEN if en_s=1, else S_IDLE; issues one push of q_s for that edge.
//    A pulse already high at reset release is captured when it closes.
//  - Writer contract: lat_en high >= 2 clk periods and low >= 2 clk periods.
//    lat_q must not change while lat_en=0 for SYNC_STAGES+1 edges after the fall.
//    Shorter pulses may be lost; no error is flagged for them.
//  - Latency: count edges from the first edge that samples lat_en=0. out_valid
//    rises SYNC_STAGES+2 edges later when the FIFO was empty (4 with defaults).
//  - FIFO: first-word fall-through. out_data is valid whenever out_valid=1, and
//    out_valid = (count != 0).
//  - Handshake: pop on out_valid && out_ready. out_data and out_valid stay stable
//    while out_valid && !out_ready.
//  - Boundaries:
//      push when count=DEPTH and no pop   -> word dropped, overflow<=1, count unchanged
//      push and pop in the same cycle at count=DEPTH -> both happen, count stays DEPTH,
//                                            no overflow
//      push and pop in the same cycle at count=0 -> no pop (out_valid=0), push lands,
//                                            count=1
//      pointers wrap modulo DEPTH; count is never above DEPTH and never below 0
//  - overflow is cleared only by reset.
//  - lat_q changing while the FSM is in S_IDLE has no effect on any output.
// STRUCTURE
//  - Package latch_rx_pkg: state typedef {S_IDLE, S_OPEN, S_CAPTURE}, and the
//    localparam function for the pointer width, clog2(DEPTH).
//  - Sub-module latch_rx_fifo (WIDTH, DEPTH): push/pop/full/empty/count, with the
//    same synchronous active-low reset.
//  - Top level holds the sync chains, the FSM and the overflow flag.
// TESTING
//  1. Reset, then lat_q=8'hA5, lat_en high 4 cycles then low, out_ready=1
//     -> single beat A5; out_valid high for 1 cycle, 4 edges after the fall
//     is sampled.
//  2. out_ready=0, four pulses carrying 01,02,03,04 -> count=4, overflow=0.
//     Then out_ready=1 -> pops 01,02,03,04 in order, count returns to 0.
//  3. Full FIFO, fifth pulse carrying 05, out_ready=0 -> overflow=1, count stays 4,
//     05 never appears at out_data.
//  4. Full FIFO, capture coincides with a pop -> count stays 4, overflow stays 0,
//     new word is last in the drain order.
//  5. Two entries held, reset driven low while in S_OPEN -> next edge: count=0,
//     out_valid=0, overflow=0. After reset returns high, the pulse that was cut
//     off produces no capture.
//  6. lat_en=0 throughout, lat_q toggled every cycle for 20 cycles
//     -> out_valid stays 0, count stays 0.

Source files
------------

// File: rtl/latch_rx_pkg.sv
// Purpose : shared types and helpers for the latch capture receiver.
// Latency : n/a (declarations only).
// Backpressure: n/a.
// Contents: FSM state encoding and the pointer-width helper used by the FIFO.
package latch_rx_pkg;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_OPEN    = 2'd1,
    S_CAPTURE = 2'd2
  } state_t;

  // Pointer width for a power-of-two FIFO; at least one bit.
  function automatic int ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/latch_rx_fifo.sv
// Purpose : first-word fall-through FIFO holding captured latch words.
// Latency : a push is visible at head/!empty one edge after it is issued.
// Backpressure: a push into a full FIFO is dropped unless a pop frees a slot that same cycle.
// Ports   : clk, reset (sync, active-low), push/push_data, pop, head, empty, full, count.
module latch_rx_fifo
  import latch_rx_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = ptr_w(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  // A pop on an empty FIFO is ignored; a push into a full FIFO lands only
  // if the same cycle's pop makes room.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + PW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/latch_capture_rx.sv
// Purpose : samples a transparent latch's value each time its enable closes and queues it.
// Latency : out_valid rises SYNC_STAGES+2 edges after the first edge that samples lat_en=0 (empty FIFO).
// Backpressure: out_ready=0 holds the head word; captures into a full FIFO are dropped and set sticky overflow.
// Ports   : clk, reset (sync, active-low), lat_en/lat_q (async latch side),
//           out_data/out_valid/out_ready (downstream handshake), count, overflow.
module latch_capture_rx
  import latch_rx_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int DEPTH       = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   lat_en,
  input  logic [WIDTH-1:0]       lat_q,
  output logic [WIDTH-1:0]       out_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [$clog2(DEPTH):0] count,
  output logic                   overflow
);

  logic [SYNC_STAGES-1:0] en_sync;
  logic [WIDTH-1:0]       q_sync [SYNC_STAGES];
  logic                   en_s;
  logic [WIDTH-1:0]       q_s;

  state_t                 state;
  logic                   push_vld;
  logic [WIDTH-1:0]       push_dat;

  logic                   fifo_empty;
  logic                   fifo_full;
  logic                   pop;

  assign en_s = en_sync[SYNC_STAGES-1];
  assign q_s  = q_sync[SYNC_STAGES-1];

  // Data is synchronized alongside the enable; the writer holds lat_q steady
  // long enough after the fall that q_s is settled when the capture fires.
  always_ff @(posedge clk) begin
    if (!reset) begin
      en_sync <= '0;
      for (int i = 0; i < SYNC_STAGES; i++) begin
        q_sync[i] <= '0;
      end
    end else begin
      en_sync   <= {en_sync[SYNC_STAGES-2:0], lat_en};
      q_sync[0] <= lat_q;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        q_sync[i] <= q_sync[i-1];
      end
    end
  end

  // Falling-edge detector on en_s; the push is registered, so it reaches the
  // FIFO one edge after the FSM leaves S_CAPTURE.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= S_IDLE;
      push_vld <= 1'b0;
      push_dat <= '0;
    end else begin
      push_vld <= 1'b0;
      case (state)
        S_IDLE: begin
          if (en_s) state <= S_OPEN;
        end
        S_OPEN: begin
          if (!en_s) state <= S_CAPTURE;
        end
        S_CAPTURE: begin
          push_vld <= 1'b1;
          push_dat <= q_s;
          state    <= en_s ? S_OPEN : S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign out_valid = !fifo_empty;
  assign pop       = out_valid && out_ready;

  // A full FIFO only refuses the word when no pop is taking place that cycle.
  always_ff @(posedge clk) begin
    if (!reset) begin
      overflow <= 1'b0;
    end else if (push_vld && fifo_full && !pop) begin
      overflow <= 1'b1;
    end
  end

  latch_rx_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push_vld),
    .push_data (push_dat),
    .pop       (pop),
    .head      (out_data),
    .empty     (fifo_empty),
    .full      (fifo_full),
    .count     (count)
  );

endmodule
